mask_row_deserializer: RTL and testbench

//  Downstream consumer of the mask serializer. Pulls one mask row as a burst of

---
 rtl/mask_row_deserializer.sv | 119 +++++++++++
 tb/tb_mask_row_deserializer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mask_row_deserializer.sv
// Reassembles one mask row from a burst of WORDS serial words, MSB-first per word.
// Latency: row_valid rises WORDS+1 edges after an accepted start (clk_en high, output free).
// Backpressure: a finished row waits in the shadow buffer (PEND) until row_out is acked or empty.
module mask_row_deserializer #(
  parameter int CHANNEL_WIDTH = 20,
  parameter int ROW_WIDTH     = 640
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clk_en,
  input  logic                     start,
  input  logic [CHANNEL_WIDTH-1:0] din,
  output logic                     next,
  output logic [0:ROW_WIDTH-1]     row_out,
  output logic                     row_valid,
  input  logic                     row_ack,
  output logic                     busy,
  output logic                     overrun,
  input  logic                     clr_err
);

  localparam int WORDS = ROW_WIDTH / CHANNEL_WIDTH;
  localparam int CNT_W = $clog2(WORDS);
  localparam int REQ_W = $clog2(WORDS + 1);

  typedef enum logic [1:0] {IDLE, FETCH, PEND} state_t;

  state_t               state;
  logic [REQ_W-1:0]     req_cnt;
  logic [CNT_W-1:0]     cap_cnt;
  logic                 cap_vld;
  logic [0:ROW_WIDTH-1] shadow;

  logic                 out_free;
  logic                 final_cap;
  logic [REQ_W-1:0]     req_nxt;
  logic [0:ROW_WIDTH-1] full_row;

  always_comb begin
    out_free  = !row_valid || row_ack;
    final_cap = cap_vld && (cap_cnt == CNT_W'(WORDS - 1));
    req_nxt   = req_cnt + REQ_W'(next);
    full_row  = shadow;
    full_row[(WORDS-1)*CHANNEL_WIDTH +: CHANNEL_WIDTH] = din;
  end

  // Shadow row is pure datapath; stale contents are never exposed before a full refill.
  always_ff @(posedge clk) begin
    if (cap_vld)
      shadow[int'(cap_cnt)*CHANNEL_WIDTH +: CHANNEL_WIDTH] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      next      <= 1'b0;
      req_cnt   <= '0;
      cap_cnt   <= '0;
      cap_vld   <= 1'b0;
      row_out   <= '0;
      row_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // A request issued this edge returns on din next edge, independent of clk_en.
      cap_vld <= next;
      if (cap_vld)
        cap_cnt <= cap_cnt + CNT_W'(1);

      if (start && busy)
        overrun <= 1'b1;
      else if (clr_err)
        overrun <= 1'b0;

      if (row_valid && row_ack)
        row_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (start && clk_en) begin
            state   <= FETCH;
            busy    <= 1'b1;
            next    <= 1'b1;
            req_cnt <= '0;
            cap_cnt <= '0;
          end
        end
        FETCH: begin
          req_cnt <= req_nxt;
          next    <= clk_en && (req_nxt < REQ_W'(WORDS));
          if (final_cap) begin
            if (out_free) begin
              row_out   <= full_row;
              row_valid <= 1'b1;
              state     <= IDLE;
              busy      <= 1'b0;
            end else begin
              state <= PEND;
            end
          end
        end
        PEND: begin
          if (out_free) begin
            row_out   <= shadow;
            row_valid <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          next  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mask_row_deserializer.sv
// Bench for mask_row_deserializer: table of word patterns, directed corner sequences,
// then randomized rows/clk_en/ack against a serializer model and an in-order row scoreboard.
module tb_mask_row_deserializer;

  localparam int CW    = 20;
  localparam int RW    = 640;
  localparam int WORDS = RW / CW;

  logic          clk;
  logic          rst_n, clk_en, start, row_ack, clr_err;
  logic [CW-1:0] din;
  logic          next, row_valid, busy, overrun;
  logic [0:RW-1] row_out;

  mask_row_deserializer #(.CHANNEL_WIDTH(CW), .ROW_WIDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start), .din(din),
    .next(next), .row_out(row_out), .row_valid(row_valid), .row_ack(row_ack),
    .busy(busy), .overrun(overrun), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_row(input string name, input logic [0:RW-1] act, input logic [0:RW-1] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Serializer model: a word requested at edge t is presented for edge t+1.
  logic          req_q = 1'b0;
  int            wcnt = 0;
  logic [CW-1:0] base = '0, stepv = '0, w;
  bit            rnd_words = 1'b0;
  logic [0:RW-1] sent_row = '0;
  logic [0:RW-1] exp_q[$];

  always @(negedge clk) begin
    if (req_q) begin
      w = rnd_words ? CW'($urandom) : base + CW'(wcnt) * stepv;
      din = w;
      if (wcnt < WORDS) sent_row[wcnt*CW +: CW] = w;
      wcnt++;
      if (wcnt == WORDS) exp_q.push_back(sent_row);
    end else begin
      din = CW'($urandom);
    end
    req_q = next;
  end

  // Random-phase scoreboard: rows accepted in order, row_out frozen while un-acked.
  bit            sb_on = 1'b0;
  bit            prev_hold = 1'b0;
  logic [0:RW-1] prev_row = '0;
  int            accepted = 0;

  always @(negedge clk) begin
    if (sb_on) begin
      if (prev_hold) begin
        check("hold_valid", 32'(row_valid), 32'd1);
        check_row("hold_row", row_out, prev_row);
      end
      if (row_valid && row_ack) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rnd_row: row accepted with no completed burst, got %h", row_out);
        end else begin
          check_row("rnd_row", row_out, exp_q.pop_front());
        end
        accepted++;
      end
      prev_hold = row_valid && !row_ack;
      prev_row  = row_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    wcnt  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int lat, input int budget);
    lat = 0;
    while (!row_valid && lat < budget) begin
      tick();
      lat++;
    end
  endtask

  task automatic ack_once();
    row_ack = 1'b1;
    tick();
    row_ack = 1'b0;
  endtask

  typedef struct {
    logic [CW-1:0] base;
    logic [CW-1:0] step;
    logic [CW-1:0] first;
    logic [CW-1:0] last;
  } vec_t;

  vec_t vt[4];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int            lat, cnt;
    logic [CW-1:0] sl;
    logic [0:RW-1] row_a, row_b, held;

    vt[0] = '{base: 20'h00000, step: 20'h00001, first: 20'h00000, last: 20'h0001F};
    vt[1] = '{base: 20'hABCDE, step: 20'h00000, first: 20'hABCDE, last: 20'hABCDE};
    vt[2] = '{base: 20'hFFFFF, step: 20'hFFFFF, first: 20'hFFFFF, last: 20'hFFFE0};
    vt[3] = '{base: 20'h12345, step: 20'h00100, first: 20'h12345, last: 20'h14245};

    rst_n = 1'b0; clk_en = 1'b1; start = 1'b0; row_ack = 1'b0; clr_err = 1'b0; din = '0;

    // Reset values and quiet period
    tick(); tick();
    check("rst_next", 32'(next), 32'd0);
    check("rst_valid", 32'(row_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check_row("rst_row", row_out, '0);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (next) cnt++;
    end
    check("idle_next_cnt", 32'(cnt), 32'd0);

    // Table-driven single rows
    for (int v = 0; v < 4; v++) begin
      base = vt[v].base; stepv = vt[v].step;
      do_start();
      check("start_busy", 32'(busy), 32'd1);
      wait_valid(lat, 100);
      check("row_latency", 32'(lat), 32'd33);
      check("next_pulses", 32'(wcnt), 32'(WORDS));
      sl = row_out[0:19];
      check("first_word", 32'(sl), 32'(vt[v].first));
      sl = row_out[620:639];
      check("last_word", 32'(sl), 32'(vt[v].last));
      check_row("table_row", row_out, sent_row);
      held = row_out;
      ack_once();
      check("ack_clears_valid", 32'(row_valid), 32'd0);
      check_row("ack_holds_row", row_out, held);
    end

    // Backpressure: second row parks in PEND, loads on the ack edge without a bubble
    base = 20'h11111; stepv = 20'h00003;
    do_start();
    wait_valid(lat, 100);
    row_a = row_out;
    check_row("bp_row_a", row_a, sent_row);
    base = 20'h22222; stepv = 20'h00005;
    do_start();
    repeat (45) tick();
    check("bp_pulses", 32'(wcnt), 32'(WORDS));
    check("bp_busy_pend", 32'(busy), 32'd1);
    check("bp_valid", 32'(row_valid), 32'd1);
    check_row("bp_row_held", row_out, row_a);
    row_b = sent_row;
    ack_once();
    check("bp_no_bubble", 32'(row_valid), 32'd1);
    check_row("bp_row_b", row_out, row_b);
    check("bp_idle", 32'(busy), 32'd0);
    ack_once();
    check("bp_drained", 32'(row_valid), 32'd0);

    // clk_en gap of 5 cycles after word 10
    base = 20'h3C3C3; stepv = 20'h00777;
    do_start();
    lat = 0;
    while (wcnt < 11 && lat < 60) begin
      tick();
      lat++;
    end
    clk_en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      lat++;
      if (next) cnt++;
    end
    clk_en = 1'b1;
    check("gap_no_next", 32'(cnt), 32'd0);
    while (!row_valid && lat < 150) begin
      tick();
      lat++;
    end
    check("gap_latency", 32'(lat), 32'd38);
    check("gap_pulses", 32'(wcnt), 32'(WORDS));
    check_row("gap_row", row_out, sent_row);
    ack_once();

    // Overrun: start mid-fetch is flagged but does not disturb the burst
    base = 20'h0F0F0; stepv = 20'h00001;
    do_start();
    repeat (4) tick();
    start = 1'b1; tick(); start = 1'b0;
    check("ovr_set", 32'(overrun), 32'd1);
    wait_valid(lat, 100);
    repeat (3) tick();
    check("ovr_pulses", 32'(wcnt), 32'(WORDS));
    check_row("ovr_row", row_out, sent_row);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("ovr_clear", 32'(overrun), 32'd0);
    ack_once();
    do_start();
    start = 1'b1; clr_err = 1'b1; tick(); start = 1'b0; clr_err = 1'b0;
    check("ovr_set_wins", 32'(overrun), 32'd1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("ovr_clear2", 32'(overrun), 32'd0);
    wait_valid(lat, 100);
    ack_once();

    // Reset mid-burst with a row still waiting
    base = 20'h5A5A5; stepv = 20'h00002;
    do_start();
    wait_valid(lat, 100);
    do_start();
    cnt = 0;
    while (wcnt < 20 && cnt < 60) begin
      tick();
      cnt++;
    end
    rst_n = 1'b0;
    #1;
    check("mrst_next", 32'(next), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_valid", 32'(row_valid), 32'd0);
    check_row("mrst_row", row_out, '0);
    tick();
    rst_n = 1'b1;
    tick();
    base = 20'h6B6B6; stepv = 20'h00007;
    do_start();
    wait_valid(lat, 100);
    check("mrst_latency", 32'(lat), 32'd33);
    check("mrst_pulses", 32'(wcnt), 32'(WORDS));
    check_row("mrst_fresh_row", row_out, sent_row);
    ack_once();

    // Randomized rows, clk_en and ack
    exp_q.delete();
    rnd_words = 1'b1;
    accepted  = 0;
    sb_on     = 1'b1;
    cnt       = 0;
    for (int c = 0; c < 20000 && !(cnt == 25 && !busy); c++) begin
      row_ack = ($urandom_range(2) == 0);
      if (!busy && cnt < 25 && $urandom_range(2) == 0) begin
        if (cnt > 0) check("rnd_burst_len", 32'(wcnt), 32'(WORDS));
        clk_en = 1'b1;
        cnt++;
        do_start();
      end else begin
        clk_en = ($urandom_range(3) != 0);
        tick();
      end
    end
    check("rnd_last_burst_len", 32'(wcnt), 32'(WORDS));
    clk_en  = 1'b1;
    row_ack = 1'b1;
    repeat (5) tick();
    sb_on   = 1'b0;
    row_ack = 1'b0;
    check("rnd_accepted", 32'(accepted), 32'd25);
    check("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
    check("rnd_overrun", 32'(overrun), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
